// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and request types.
// The encoder and the control-unit decoder both use these.
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [1:0] {
        CLS_R   = 2'b00,
        CLS_LW  = 2'b01,
        CLS_SW  = 2'b10,
        CLS_BEQ = 2'b11
    } cls_e;

    typedef struct packed {
        cls_e        cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [12:0] imm;
    } instr_req_t;

    // A branch offset must be even; a 12-bit load/store offset must sign-extend cleanly.
    function automatic logic imm_in_range(input instr_req_t r);
        case (r.cls)
            CLS_LW, CLS_SW: return r.imm[12] == r.imm[11];
            CLS_BEQ:        return !r.imm[0];
            default:        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Request bus and instruction-word output stream of rv_instr_encoder.
interface rv_instr_encoder_if #(
    parameter int unsigned AW = 12
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_cls;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [2:0]    req_f3;
    logic          req_f7b5;
    logic [12:0]   req_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err;

    modport master (
        output req_valid, req_cls, req_rd, req_rs1, req_rs2, req_f3, req_f7b5, req_imm,
        output out_ready,
        input  req_ready, out_valid, out_instr, out_addr, err
    );

    modport slave (
        input  req_valid, req_cls, req_rd, req_rs1, req_rs2, req_f3, req_f7b5, req_imm,
        input  out_ready,
        output req_ready, out_valid, out_instr, out_addr, err
    );
endinterface

// File: rtl/rv_instr_encoder_sync_fifo.sv
// Synchronous FIFO with a registered head word; the head holds its last value when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_wr, do_rd;

    assign full  = count_q == (PW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign do_rd = rd_en && !empty && !flush;
    assign do_wr = wr_en && (!full || do_rd) && !flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, do_wr} - {{PW{1'b0}}, do_rd};
            // The next head is the word being written when it lands in the slot about to be read.
            if (count_d != '0)
                head_d = (do_wr && wr_ptr_q == rd_ptr_d) ? wr_data : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = head_q;

endmodule

// File: rtl/rv_instr_encoder.sv
// Encodes R/LW/SW/BEQ requests into RV32I words, queues them and streams them with byte addresses.
// Optional RANGE_CHECK_EN: reject odd branch offsets and non-sign-extending LW/SW offsets with an err pulse.
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned   DEPTH     = 4,
    parameter int unsigned   AW        = 12,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input logic               clk,
    input logic               rst_n,
    input logic               restart,
    rv_instr_encoder_if.slave bus
);

    function automatic logic [31:0] encode(input instr_req_t r);
        logic [31:0] w;
        case (r.cls)
            CLS_R:   w = {1'b0, r.f7b5, 5'b0, r.rs2, r.rs1, r.f3, r.rd, OPC_OP};
            CLS_LW:  w = {r.imm[11:0], r.rs1, F3_W, r.rd, OPC_LOAD};
            CLS_SW:  w = {r.imm[11:5], r.rs2, r.rs1, F3_W, r.imm[4:0], OPC_STORE};
            default: w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, F3_BEQ, r.imm[4:1], r.imm[11], OPC_BRANCH};
        endcase
        return w;
    endfunction

    instr_req_t    req_s;
    logic [31:0]   instr_s;
    logic [31:0]   head;
    logic          full, empty;
    logic          accept, bad, push, pop;
    logic [AW-1:0] addr_q, addr_d;

    always_comb begin
        req_s.cls  = cls_e'(bus.req_cls);
        req_s.rd   = bus.req_rd;
        req_s.rs1  = bus.req_rs1;
        req_s.rs2  = bus.req_rs2;
        req_s.f3   = bus.req_f3;
        req_s.f7b5 = bus.req_f7b5;
        req_s.imm  = bus.req_imm;
    end

    assign instr_s = encode(req_s);
    assign accept  = bus.req_valid && !full;

`ifdef RANGE_CHECK_EN
    logic err_q, err_d;

    assign bad   = !imm_in_range(req_s);
    assign err_d = accept && bad && !restart;

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    logic unused_imm_lsb;

    assign bad            = 1'b0;
    assign unused_imm_lsb = req_s.imm[0];
    assign bus.err        = 1'b0;
`endif

    // restart outranks both handshakes: the request that cycle is dropped and nothing is popped.
    assign push = accept && !bad && !restart;
    assign pop  = bus.out_ready && !empty && !restart;

    always_comb begin
        addr_d = addr_q;
        if (restart)  addr_d = BASE_ADDR;
        else if (pop) addr_d = addr_q + AW'(4);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) addr_q <= BASE_ADDR;
        else        addr_q <= addr_d;
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (restart),
        .wr_en   (push),
        .wr_data (instr_s),
        .rd_en   (pop),
        .full    (full),
        .empty   (empty),
        .rd_data (head)
    );

    assign bus.req_ready = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = head;
    assign bus.out_addr  = addr_q;

endmodule
